regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
- Parametrised integer register file with two write ports:
  - pipeline write-back (wb_*)
  - memory-controller load return (ld_*)
- Keeps a per-register pending-load scoreboard so the core can stall on RAW hazards against outstanding loads.
- Provides write-to-read bypass and sticky hazard-error flags.
- Sits between the RISC-V decode/writeback stages and the memory controller response path.

Parameters:
- DATA_WIDTH, 32, register width in bits
- NUM_REGS, 32, number of architectural registers; index 0 hardwired to zero
- ADDR_W, 5, register index width; must equal clog2(NUM_REGS)
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see array only
- CNT_W, 6, outstanding-load counter width; must equal clog2(NUM_REGS+1)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-low
- rs1_addr  in  ADDR_W  read port 1 index
- rs2_addr  in  ADDR_W  read port 2 index
- rs1_data  out  DATA_WIDTH  read port 1 data (combinational)
- rs2_data  out  DATA_WIDTH  read port 2 data (combinational)
- rs1_busy  out  1  read port 1 register awaits a load
- rs2_busy  out  1  read port 2 register awaits a load
- wb_we  in  1  write-back enable
- wb_addr  in  ADDR_W  write-back index
- wb_data  in  DATA_WIDTH  write-back data
- ld_issue  in  1  load issued to memory controller; marks ld_issue_addr busy
- ld_issue_addr  in  ADDR_W  destination of issued load
- ld_ret_valid  in  1  load data returning this cycle; always accepted
- ld_ret_addr  in  ADDR_W  destination of returning load
- ld_ret_data  in  DATA_WIDTH  returned load data
- outstanding  out  CNT_W  count of busy registers
- err_waw  out  1  sticky: write-back to a busy register, or wb/ld_ret collision
- err_spurious  out  1  sticky: load return to a non-busy register

Behaviour:
- Reset (rst==0 at posedge clk): all registers 0, all busy bits 0, outstanding 0, err_waw 0, err_spurious 0.
  - Reset takes priority over every other input.
  - Reset mid-operation discards pending loads; later ld_ret to those registers sets err_spurious.
- Register 0:
  - Reads return 0 and busy 0.
  - Writes, issues and returns addressed to 0 are ignored and never set errors.
- Writes, at posedge when rst==1:
  - wb_we writes wb_data.
  - ld_ret_valid writes ld_ret_data and clears the busy bit.
  - Different addresses: both writes occur.
  - Same nonzero address on both ports: ld_ret_data is written, wb write dropped, err_waw set.
- Reads:
  - Combinational, zero latency.
  - With BYPASS=1, the read result is selected in this priority order:
    1. matching ld_ret_valid → ld_ret_data
    2. matching wb_we → wb_data
    3. array contents
  - With BYPASS=0, reads return array contents; the new value is visible the cycle after the write.
- Busy outputs:
  - rsN_busy = busy[rsN_addr] AND NOT (ld_ret_valid AND ld_ret_addr==rsN_addr).
  - The AND-NOT return term applies only when BYPASS=1; with BYPASS=0, busy clears one cycle after the return.
- Scoreboard:
  - ld_issue sets busy[ld_issue_addr] at posedge.
  - Same-cycle ld_issue and ld_ret to the same address: data written, busy stays 1 (the new load owns it).
  - ld_issue to an already-busy register: busy stays 1, no error.
- outstanding:
  - Equals the population count of the busy bits.
  - Updated incrementally: +1 on new set, −1 on clear; net 0 when set and clear hit different registers in one cycle.
  - Never wraps, because it is bounded by NUM_REGS−1.
- Errors:
  - err_waw sets when wb_we hits a busy register not being returned the same cycle; the write is still performed.
  - err_spurious sets when ld_ret_valid targets a non-busy register; the data is still written.
  - Both flags clear only on reset.

Decomposition:
- Shared package (rv_pkg): DATA_WIDTH/ADDR_W defaults, REG_ZERO constant, reg-index typedef.
- One sub-module, regfile_bypass_mux: the per-read-port priority mux and busy masking, instantiated twice.

Test Plan:
- Reset then read all 32 indices → all data 0, busy 0, outstanding 0, errors 0.
- wb_we addr 5 data 0xDEADBEEF, rs1_addr 5 same cycle → rs1_data 0xDEADBEEF (BYPASS=1); next cycle still 0xDEADBEEF; write to addr 0 → rs2_addr 0 reads 0.
- ld_issue addr 7 → next cycle rs1_busy 1, outstanding 1; 3 cycles later ld_ret addr 7 data 0x1234 → same cycle rs1_busy 0, rs1_data 0x1234; next cycle outstanding 0.
- Same cycle wb_we addr 9 data 0xAAAA and ld_ret addr 9 data 0x5555 with busy[9]=1 → reg 9 = 0x5555, err_waw 1.
- ld_ret addr 3 with busy[3]=0 → reg 3 updated, err_spurious 1; persists until rst low at posedge.
- ld_issue addr 4 and ld_ret addr 4 same cycle (busy[4]=1) → reg 4 written, busy[4] stays 1, outstanding unchanged.

Source files
------------

// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared register-file defaults and index type
package rv_pkg;
  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_ADDR_W     = 5;
  localparam int unsigned REG_ZERO       = 0;

  typedef logic [DEF_ADDR_W-1:0] reg_idx_t;
endpackage

// File: rtl/regfile_bypass_mux.sv
// rtl/regfile_bypass_mux.sv - per-read-port forwarding mux and busy masking
module regfile_bypass_mux
  import rv_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int BYPASS     = 1
) (
  input  logic [ADDR_W-1:0]     rd_addr,
  input  logic [DATA_WIDTH-1:0] arr_data,
  input  logic                  arr_busy,
  input  logic                  wb_we,
  input  logic [ADDR_W-1:0]     wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  input  logic                  ld_ret_valid,
  input  logic [ADDR_W-1:0]     ld_ret_addr,
  input  logic [DATA_WIDTH-1:0] ld_ret_data,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_busy
);
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  logic ret_match;
  logic wb_match;

  assign ret_match = ld_ret_valid && (ld_ret_addr == rd_addr);
  assign wb_match  = wb_we && (wb_addr == rd_addr);

  always_comb begin
    rd_data = arr_data;
    rd_busy = arr_busy;
    // A returning load beats write-back, matching what the array will hold next cycle.
    if (BYPASS != 0) begin
      if (ret_match) begin
        rd_data = ld_ret_data;
        rd_busy = 1'b0;
      end else if (wb_match) begin
        rd_data = wb_data;
      end
    end
    if (rd_addr == ZERO_IDX) begin
      rd_data = '0;
      rd_busy = 1'b0;
    end
  end
endmodule

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - register file with pending-load scoreboard and hazard flags
module regfile_scoreboard
  import rv_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_REGS   = 32,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int BYPASS     = 1,
  parameter int CNT_W      = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     rs1_addr,
  input  logic [ADDR_W-1:0]     rs2_addr,
  output logic [DATA_WIDTH-1:0] rs1_data,
  output logic [DATA_WIDTH-1:0] rs2_data,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  input  logic                  wb_we,
  input  logic [ADDR_W-1:0]     wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  input  logic                  ld_issue,
  input  logic [ADDR_W-1:0]     ld_issue_addr,
  input  logic                  ld_ret_valid,
  input  logic [ADDR_W-1:0]     ld_ret_addr,
  input  logic [DATA_WIDTH-1:0] ld_ret_data,
  output logic [CNT_W-1:0]      outstanding,
  output logic                  err_waw,
  output logic                  err_spurious
);
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0]   busy;

  logic wb_hit, ret_hit, iss_hit, collide;
  logic busy_set_new, busy_clr;

  assign wb_hit  = wb_we && (wb_addr != ZERO_IDX);
  assign ret_hit = ld_ret_valid && (ld_ret_addr != ZERO_IDX);
  assign iss_hit = ld_issue && (ld_issue_addr != ZERO_IDX);
  assign collide = wb_hit && ret_hit && (wb_addr == ld_ret_addr);

  // A same-cycle reissue keeps the bit set, so the return does not count as a clear.
  assign busy_set_new = iss_hit && !busy[ld_issue_addr];
  assign busy_clr     = ret_hit && busy[ld_ret_addr] &&
                        !(iss_hit && (ld_issue_addr == ld_ret_addr));

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      busy         <= '0;
      outstanding  <= '0;
      err_waw      <= 1'b0;
      err_spurious <= 1'b0;
    end else begin
      if (wb_hit && !collide) regs[wb_addr] <= wb_data;
      if (ret_hit) begin
        regs[ld_ret_addr] <= ld_ret_data;
        busy[ld_ret_addr] <= 1'b0;
      end
      if (iss_hit) busy[ld_issue_addr] <= 1'b1;
      case ({busy_set_new, busy_clr})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
      if (wb_hit && (busy[wb_addr] || collide)) err_waw <= 1'b1;
      if (ret_hit && !busy[ld_ret_addr]) err_spurious <= 1'b1;
    end
  end

  regfile_bypass_mux #(
    .DATA_WIDTH(DATA_WIDTH), .ADDR_W(ADDR_W), .BYPASS(BYPASS)
  ) u_rs1_mux (
    .rd_addr(rs1_addr), .arr_data(regs[rs1_addr]), .arr_busy(busy[rs1_addr]),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .ld_ret_valid(ld_ret_valid), .ld_ret_addr(ld_ret_addr), .ld_ret_data(ld_ret_data),
    .rd_data(rs1_data), .rd_busy(rs1_busy)
  );

  regfile_bypass_mux #(
    .DATA_WIDTH(DATA_WIDTH), .ADDR_W(ADDR_W), .BYPASS(BYPASS)
  ) u_rs2_mux (
    .rd_addr(rs2_addr), .arr_data(regs[rs2_addr]), .arr_busy(busy[rs2_addr]),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .ld_ret_valid(ld_ret_valid), .ld_ret_addr(ld_ret_addr), .ld_ret_data(ld_ret_data),
    .rd_data(rs2_data), .rd_busy(rs2_busy)
  );
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - directed and randomized checks against a behavioural model
module tb_regfile_scoreboard;
  import rv_pkg::*;

  localparam int DW = 32;
  localparam int NR = 32;
  localparam int AW = 5;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] rs1_addr, rs2_addr;
  logic [DW-1:0] rs1_data, rs2_data;
  logic          rs1_busy, rs2_busy;
  logic          wb_we;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          ld_issue;
  logic [AW-1:0] ld_issue_addr;
  logic          ld_ret_valid;
  logic [AW-1:0] ld_ret_addr;
  logic [DW-1:0] ld_ret_data;
  logic [CW-1:0] outstanding;
  logic          err_waw, err_spurious;

  always #5 clk = ~clk;

  regfile_scoreboard #(
    .DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_W(AW), .BYPASS(1), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .ld_issue(ld_issue), .ld_issue_addr(ld_issue_addr),
    .ld_ret_valid(ld_ret_valid), .ld_ret_addr(ld_ret_addr), .ld_ret_data(ld_ret_data),
    .outstanding(outstanding), .err_waw(err_waw), .err_spurious(err_spurious)
  );

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] m_regs [NR];
  bit            m_busy [NR];
  bit            m_waw, m_spur;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] exp_data(input reg_idx_t a);
    if (a == 0) return '0;
    if (ld_ret_valid && ld_ret_addr == a) return ld_ret_data;
    if (wb_we && wb_addr == a) return wb_data;
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input reg_idx_t a);
    if (a == 0) return 1'b0;
    if (ld_ret_valid && ld_ret_addr == a) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic int busy_count();
    int n = 0;
    for (int i = 0; i < NR; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  task automatic check_all(input string tag);
    check_eq({tag, ":rs1_data"}, rs1_data, exp_data(rs1_addr));
    check_eq({tag, ":rs2_data"}, rs2_data, exp_data(rs2_addr));
    check_eq({tag, ":rs1_busy"}, 32'(rs1_busy), 32'(exp_busy(rs1_addr)));
    check_eq({tag, ":rs2_busy"}, 32'(rs2_busy), 32'(exp_busy(rs2_addr)));
    check_eq({tag, ":outstanding"}, 32'(outstanding), 32'(busy_count()));
    check_eq({tag, ":err_waw"}, 32'(err_waw), 32'(m_waw));
    check_eq({tag, ":err_spurious"}, 32'(err_spurious), 32'(m_spur));
  endtask

  task automatic model_update();
    bit wbh, reth, issh, coll, bw, br;
    if (!rst) begin
      for (int i = 0; i < NR; i++) begin
        m_regs[i] = '0;
        m_busy[i] = 1'b0;
      end
      m_waw  = 1'b0;
      m_spur = 1'b0;
      return;
    end
    wbh  = wb_we && wb_addr != 0;
    reth = ld_ret_valid && ld_ret_addr != 0;
    issh = ld_issue && ld_issue_addr != 0;
    coll = wbh && reth && wb_addr == ld_ret_addr;
    bw   = m_busy[wb_addr];
    br   = m_busy[ld_ret_addr];
    if (wbh && !coll) m_regs[wb_addr] = wb_data;
    if (reth) begin
      m_regs[ld_ret_addr] = ld_ret_data;
      m_busy[ld_ret_addr] = 1'b0;
    end
    if (issh) m_busy[ld_issue_addr] = 1'b1;
    if (wbh && (bw || coll)) m_waw = 1'b1;
    if (reth && !br) m_spur = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    rst = 1'b1; wb_we = 1'b0; ld_issue = 1'b0; ld_ret_valid = 1'b0;
    wb_addr = '0; wb_data = '0; ld_issue_addr = '0; ld_ret_addr = '0; ld_ret_data = '0;
  endtask

  function automatic reg_idx_t pick();
    if ($urandom_range(0, 9) < 7) return reg_idx_t'($urandom_range(0, 7));
    return reg_idx_t'($urandom_range(0, NR - 1));
  endfunction

  initial begin
    int q[$];
    for (int i = 0; i < NR; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
    m_waw = 1'b0; m_spur = 1'b0;
    idle(); rs1_addr = '0; rs2_addr = '0;
    rst = 1'b0;
    tick();
    rst = 1'b1;

    // Reset state on every index
    for (int i = 0; i < NR; i++) begin
      rs1_addr = AW'(i); rs2_addr = AW'(NR - 1 - i);
      #1;
      check_eq("reset_rs1_data", rs1_data, 32'h0);
      check_eq("reset_rs1_busy", 32'(rs1_busy), 32'h0);
    end
    check_eq("reset_outstanding", 32'(outstanding), 32'h0);
    check_eq("reset_errs", {30'h0, err_waw, err_spurious}, 32'h0);

    // Write-back with same-cycle bypass, then write to x0
    wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF; rs1_addr = 5'd5;
    #1 check_eq("wb_bypass", rs1_data, 32'hDEADBEEF);
    tick(); idle();
    #1 check_eq("wb_stored", rs1_data, 32'hDEADBEEF);
    wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF; rs2_addr = 5'd0;
    #1 check_eq("x0_bypass", rs2_data, 32'h0);
    tick(); idle();
    #1 check_eq("x0_stored", rs2_data, 32'h0);

    // Load issue, wait, return with bypass
    ld_issue = 1'b1; ld_issue_addr = 5'd7;
    tick(); idle(); rs1_addr = 5'd7;
    #1 check_eq("ld7_busy", 32'(rs1_busy), 32'h1);
    check_eq("ld7_outstanding", 32'(outstanding), 32'h1);
    tick(); tick(); tick();
    ld_ret_valid = 1'b1; ld_ret_addr = 5'd7; ld_ret_data = 32'h1234;
    #1 check_eq("ld7_ret_busy", 32'(rs1_busy), 32'h0);
    check_eq("ld7_ret_data", rs1_data, 32'h1234);
    tick(); idle();
    #1 check_eq("ld7_done_outstanding", 32'(outstanding), 32'h0);
    check_all("ld7");

    // wb and ld_ret collision on a busy register
    ld_issue = 1'b1; ld_issue_addr = 5'd9;
    tick(); idle();
    wb_we = 1'b1; wb_addr = 5'd9; wb_data = 32'hAAAA;
    ld_ret_valid = 1'b1; ld_ret_addr = 5'd9; ld_ret_data = 32'h5555;
    tick(); idle(); rs1_addr = 5'd9;
    #1 check_eq("coll_data", rs1_data, 32'h5555);
    check_eq("coll_waw", 32'(err_waw), 32'h1);
    check_all("coll");

    // Spurious return persists until reset
    ld_ret_valid = 1'b1; ld_ret_addr = 5'd3; ld_ret_data = 32'h77;
    tick(); idle(); rs1_addr = 5'd3;
    #1 check_eq("spur_data", rs1_data, 32'h77);
    check_eq("spur_flag", 32'(err_spurious), 32'h1);
    tick(); tick();
    check_eq("spur_sticky", 32'(err_spurious), 32'h1);
    rst = 1'b0;
    tick(); idle();
    #1 check_eq("spur_cleared", 32'(err_spurious), 32'h0);
    check_eq("waw_cleared", 32'(err_waw), 32'h0);

    // Reissue and return to the same busy register in one cycle
    ld_issue = 1'b1; ld_issue_addr = 5'd4;
    tick(); idle();
    ld_issue = 1'b1; ld_issue_addr = 5'd4;
    ld_ret_valid = 1'b1; ld_ret_addr = 5'd4; ld_ret_data = 32'h99;
    tick(); idle(); rs1_addr = 5'd4;
    #1 check_eq("reissue_busy", 32'(rs1_busy), 32'h1);
    check_eq("reissue_data", rs1_data, 32'h99);
    check_eq("reissue_outstanding", 32'(outstanding), 32'h1);
    check_all("reissue");

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      idle();
      rst = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      wb_we = 1'($urandom_range(0, 1));
      wb_addr = pick(); wb_data = $urandom;
      ld_issue = ($urandom_range(0, 2) == 0);
      ld_issue_addr = pick();
      q.delete();
      for (int i = 1; i < NR; i++) if (m_busy[i]) q.push_back(i);
      if (q.size() > 0 && $urandom_range(0, 1) == 1) begin
        ld_ret_valid = 1'b1;
        ld_ret_addr = AW'(q[$urandom_range(0, q.size() - 1)]);
      end else if ($urandom_range(0, 9) == 0) begin
        ld_ret_valid = 1'b1;
        ld_ret_addr = pick();
      end
      ld_ret_data = $urandom;
      case ($urandom_range(0, 3))
        0: rs1_addr = wb_addr;
        1: rs1_addr = ld_ret_addr;
        default: rs1_addr = pick();
      endcase
      rs2_addr = ($urandom_range(0, 1) == 1) ? ld_issue_addr : pick();
      #1 check_all("rnd");
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
